// File: rtl/cache_fill_fsm.sv
// Block-fill miss handler for the 2-way L1 cache: latches the missing block,
// streams 8 word reads to main memory and steers returning words into the data/tag arrays.
module cache_fill_fsm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        memory_en,
   output logic [15:0] memory_address,
   output logic [15:0] fill_address,
   output logic        write_data_array,
   output logic [7:0]  word_enable,
   output logic        write_tag_array
);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } state_t;

   state_t      state_r,     state_s;
   logic [11:0] blk_r,       blk_s;
   logic [3:0]  issue_cnt_r, issue_cnt_s;
   logic [2:0]  recv_cnt_r,  recv_cnt_s;

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         blk_r       <= 12'h000;
         issue_cnt_r <= 4'd0;
         recv_cnt_r  <= 3'd0;
      end else begin
         state_r     <= state_s;
         blk_r       <= blk_s;
         issue_cnt_r <= issue_cnt_s;
         recv_cnt_r  <= recv_cnt_s;
      end
   end

   // Next-state, counter update and strobe decode.
   always_comb begin
      state_s          = state_r;
      blk_s            = blk_r;
      issue_cnt_s      = issue_cnt_r;
      recv_cnt_s       = recv_cnt_r;
      fsm_busy         = 1'b0;
      memory_en        = 1'b0;
      write_data_array = 1'b0;
      word_enable      = 8'h00;
      write_tag_array  = 1'b0;
      case (state_r)
         IDLE: begin
            // Busy in the miss cycle itself so the missing access stalls immediately.
            if (miss_detected) begin
               fsm_busy    = 1'b1;
               blk_s       = miss_address[15:4];
               issue_cnt_s = 4'd0;
               recv_cnt_s  = 3'd0;
               state_s     = FILL;
            end else begin
               fsm_busy    = 1'b0;
            end
         end
         FILL: begin
            fsm_busy = 1'b1;
            if (issue_cnt_r < 4'd8) begin
               memory_en   = 1'b1;
               issue_cnt_s = issue_cnt_r + 4'd1;
            end else begin
               memory_en   = 1'b0;
            end
            // Returns arrive in request order, so recv_cnt names the word slot.
            if (memory_data_valid) begin
               write_data_array = 1'b1;
               word_enable      = 8'h01 << recv_cnt_r;
               recv_cnt_s       = recv_cnt_r + 3'd1;
               if (recv_cnt_r == 3'd7) begin
                  write_tag_array = 1'b1;
                  state_s         = IDLE;
               end else begin
                  write_tag_array = 1'b0;
               end
            end else begin
               write_data_array = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign memory_address = {blk_r, issue_cnt_r[2:0], 1'b0};
   assign fill_address   = {blk_r, 4'h0};

endmodule
